// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 frame receiver: register map, FSM states,
// frame geometry and the decoded frame payload.
package max7219_pkg;

  localparam int unsigned FRAME_BITS_DEF = 16;
  localparam int unsigned CNT_W          = 5;
  localparam int unsigned ADDR_W         = 4;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned NUM_ROWS       = 8;

  localparam logic [ADDR_W-1:0] NOOP      = 4'h0;
  localparam logic [ADDR_W-1:0] DIGIT0    = 4'h1;
  localparam logic [ADDR_W-1:0] DIGIT1    = 4'h2;
  localparam logic [ADDR_W-1:0] DIGIT2    = 4'h3;
  localparam logic [ADDR_W-1:0] DIGIT3    = 4'h4;
  localparam logic [ADDR_W-1:0] DIGIT4    = 4'h5;
  localparam logic [ADDR_W-1:0] DIGIT5    = 4'h6;
  localparam logic [ADDR_W-1:0] DIGIT6    = 4'h7;
  localparam logic [ADDR_W-1:0] DIGIT7    = 4'h8;
  localparam logic [ADDR_W-1:0] DECODE    = 4'h9;
  localparam logic [ADDR_W-1:0] INTENSITY = 4'hA;
  localparam logic [ADDR_W-1:0] SCANLIMIT = 4'hB;
  localparam logic [ADDR_W-1:0] SHUTDOWN  = 4'hC;
  localparam logic [ADDR_W-1:0] DISPTEST  = 4'hF;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_LATCH     = 2'd3
  } state_t;

  // Low 12 bits of a frame: D11..D8 address, D7..D0 data.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/max7219_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with single-clock rise/fall
// pulses derived from the synchronized level.
module max7219_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] stg_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      stg_q  <= {stg_q[SYNC_STAGES-2:0], async_in};
      prev_q <= stg_q[SYNC_STAGES-1];
    end
  end

  assign sync   = stg_q[SYNC_STAGES-1];
  assign rise_c = sync & ~prev_q;
  assign fall_c = ~sync & prev_q;

endmodule

// File: rtl/max7219_frame_receiver.sv
// MAX7219 link monitor: reassembles serial frames and mirrors the register file.
// Define MAX7219_DOUT_EN to drive spi_dout with daisy-chain data; otherwise it is tied 0.
module max7219_frame_receiver
  import max7219_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_din,
  input  logic              spi_sclk,
  input  logic              spi_load,
  output logic              spi_dout,
  output logic              frame_valid,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_err,
  input  logic [2:0]        rd_row,
  output logic [DATA_W-1:0] rd_data,
  output logic [7:0]        decode_mode,
  output logic [3:0]        intensity,
  output logic [2:0]        scan_limit,
  output logic              shutdown_n,
  output logic              display_test
);

  logic din_sync, din_rise_c, din_fall_c;
  logic sclk_sync, sclk_rise_c, sclk_fall_c;
  logic load_sync, load_rise_c, load_fall_c;

  max7219_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .async_in(spi_din),
    .sync(din_sync), .rise_c(din_rise_c), .fall_c(din_fall_c)
  );
  max7219_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_in(spi_sclk),
    .sync(sclk_sync), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );
  max7219_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
    .clk(clk), .rst_n(rst_n), .async_in(spi_load),
    .sync(load_sync), .rise_c(load_rise_c), .fall_c(load_fall_c)
  );

  state_t                state_q, state_d;
  logic                  shift_en_c, clr_cnt_c, latch_c, frame_ok_c;
  logic [FRAME_BITS-1:0] shreg_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     rows_q [NUM_ROWS];
  frame_t                last_q, frm_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_WAIT_IDLE;
    else        state_q <= state_d;
  end

  // WAIT_IDLE skips any frame already in progress when reset releases.
  always_comb begin
    state_d    = state_q;
    shift_en_c = 1'b0;
    clr_cnt_c  = 1'b0;
    latch_c    = 1'b0;
    case (state_q)
      ST_WAIT_IDLE: if (load_sync) state_d = ST_IDLE;
      ST_IDLE: begin
        if (load_fall_c) begin
          state_d   = ST_SHIFT;
          clr_cnt_c = 1'b1;
        end
      end
      ST_SHIFT: begin
        shift_en_c = sclk_rise_c;
        if (load_rise_c) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        latch_c = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_WAIT_IDLE;
    endcase
  end

  // Shift register keeps the newest FRAME_BITS bits; count saturates for long chains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (clr_cnt_c) begin
      cnt_q <= '0;
    end else if (shift_en_c) begin
      shreg_q <= {shreg_q[FRAME_BITS-2:0], din_sync};
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign frm_c      = frame_t'(shreg_q[ADDR_W+DATA_W-1:0]);
  assign frame_ok_c = latch_c && (cnt_q >= CNT_W'(FRAME_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
      last_q       <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
      rd_data      <= '0;
      for (int i = 0; i < int'(NUM_ROWS); i++) rows_q[i] <= '0;
    end else begin
      frame_valid <= frame_ok_c;
      frame_err   <= latch_c && !frame_ok_c;
      rd_data     <= rows_q[rd_row];
      if (frame_ok_c) begin
        last_q <= frm_c;
        case (frm_c.addr)
          DIGIT0, DIGIT1, DIGIT2, DIGIT3,
          DIGIT4, DIGIT5, DIGIT6, DIGIT7: rows_q[3'(frm_c.addr - 4'd1)] <= frm_c.data;
          DECODE:    decode_mode  <= frm_c.data;
          INTENSITY: intensity    <= frm_c.data[3:0];
          SCANLIMIT: scan_limit   <= frm_c.data[2:0];
          SHUTDOWN:  shutdown_n   <= frm_c.data[0];
          DISPTEST:  display_test <= frm_c.data[0];
          NOOP:      ;
          default:   ;
        endcase
      end
    end
  end

  assign frame_addr = last_q.addr;
  assign frame_data = last_q.data;

`ifdef MAX7219_DOUT_EN
  logic dout_q;

  // Chained-device output: oldest held bit presented on each sclk fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           dout_q <= 1'b0;
    else if (sclk_fall_c) dout_q <= shreg_q[FRAME_BITS-1];
  end

  assign spi_dout = dout_q;
`else
  assign spi_dout = 1'b0;
`endif

  logic unused_sig;
  assign unused_sig = ^{din_rise_c, din_fall_c, sclk_sync, sclk_fall_c, load_sync,
                        shreg_q[FRAME_BITS-1:ADDR_W+DATA_W]};

endmodule

// File: tb/tb_max7219_frame_receiver.sv
// Directed bench for max7219_frame_receiver: scoreboarded frames plus register,
// error, reset and daisy-chain checks.
module tb_max7219_frame_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_din = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_load = 1'b1;
  logic       spi_dout;
  logic       frame_valid;
  logic [3:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_err;
  logic [2:0] rd_row = 3'd0;
  logic [7:0] rd_data;
  logic [7:0] decode_mode;
  logic [3:0] intensity;
  logic [2:0] scan_limit;
  logic       shutdown_n;
  logic       display_test;

  int tests_run = 0;
  int tests_failed = 0;
  int err_seen = 0;
  int err_exp = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  max7219_frame_receiver dut (
    .clk(clk), .rst_n(rst_n),
    .spi_din(spi_din), .spi_sclk(spi_sclk), .spi_load(spi_load), .spi_dout(spi_dout),
    .frame_valid(frame_valid), .frame_addr(frame_addr), .frame_data(frame_data),
    .frame_err(frame_err), .rd_row(rd_row), .rd_data(rd_data),
    .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
    .shutdown_n(shutdown_n), .display_test(display_test)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] word, input int n);
    spi_load = 1'b0;
    tick(3);
    for (int i = n - 1; i >= 0; i--) begin
      spi_din = word[i];
      tick(2);
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
      tick(2);
    end
  endtask

  task automatic end_frame();
    spi_load = 1'b1;
    tick(10);
  endtask

  // Scoreboard: every accepted frame must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) err_seen++;
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(frame_valid), 32'd0);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check("sb_addr", 32'(frame_addr), 32'(e[11:8]));
          check("sb_data", 32'(frame_data), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    int lat;
    logic [31:0] chain;
    logic        dout_exp;

    // Reset state
    tick(3);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_addr", 32'(frame_addr), 32'd0);
    check("rst_data", 32'(frame_data), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    check("rst_shdn", 32'(shutdown_n), 32'd0);
    check("rst_dout", 32'(spi_dout), 32'd0);
    rst_n = 1'b1;
    tick(6);

    // 1: shutdown register, with load-to-valid latency
    exp_q.push_back(12'hC01);
    shift_bits(32'h0C01, 16);
    spi_load = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (frame_valid && lat == 0) lat = k;
    end
    check("latency", 32'(lat), 32'd4);
    tick(4);
    check("t1_shdn", 32'(shutdown_n), 32'd1);
    check("t1_pending", 32'(exp_q.size()), 32'd0);
    check("t1_err", 32'(err_seen), 32'(err_exp));

    // 2: digit rows and readback
    exp_q.push_back(12'h155);
    shift_bits(32'h0155, 16);
    end_frame();
    exp_q.push_back(12'h8AA);
    shift_bits(32'h08AA, 16);
    end_frame();
    rd_row = 3'd0;
    tick(1);
    check("t2_row0", 32'(rd_data), 32'h55);
    rd_row = 3'd7;
    tick(1);
    check("t2_row7", 32'(rd_data), 32'hAA);
    rd_row = 3'd3;
    tick(1);
    check("t2_row3", 32'(rd_data), 32'h00);
    check("t2_pending", 32'(exp_q.size()), 32'd0);

    // 3: short frame is dropped with an error
    err_exp++;
    shift_bits(32'h3A5, 10);
    end_frame();
    check("t3_err", 32'(err_seen), 32'(err_exp));
    check("t3_addr_hold", 32'(frame_addr), 32'h8);
    check("t3_data_hold", 32'(frame_data), 32'hAA);
    check("t3_shdn", 32'(shutdown_n), 32'd1);
    rd_row = 3'd0;
    tick(1);
    check("t3_row0", 32'(rd_data), 32'h55);

    // 4: overlong frame keeps the last 16 bits
    exp_q.push_back(12'hA03);
    shift_bits(32'h0A0F_0A03, 32);
    end_frame();
    check("t4_int", 32'(intensity), 32'h3);
    check("t4_pending", 32'(exp_q.size()), 32'd0);
    check("t4_err", 32'(err_seen), 32'(err_exp));

    // 5: reset mid-frame discards the partial frame
    shift_bits(32'h0B, 8);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] lo;
      lo = 8'h07;
      spi_din = lo[i];
      tick(2);
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
      tick(2);
    end
    end_frame();
    check("t5_scan0", 32'(scan_limit), 32'd0);
    check("t5_int0", 32'(intensity), 32'd0);
    check("t5_pending", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(12'hB07);
    shift_bits(32'h0B07, 16);
    end_frame();
    check("t5_scan7", 32'(scan_limit), 32'd7);
    check("t5_pending2", 32'(exp_q.size()), 32'd0);

    // 6: daisy-chain output on the second 16 clocks; final frame is a no-op
    chain = 32'h0F01_0000;
    exp_q.push_back(12'h000);
    spi_load = 1'b0;
    tick(3);
    for (int i = 31; i >= 0; i--) begin
      spi_din = chain[i];
      tick(2);
      if (i <= 15) begin
`ifdef MAX7219_DOUT_EN
        dout_exp = chain[16 + i];
`else
        dout_exp = 1'b0;
`endif
        check($sformatf("t6_dout_%0d", 32 - i), 32'(spi_dout), 32'(dout_exp));
      end
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
      tick(2);
    end
    end_frame();
    check("t6_disptest", 32'(display_test), 32'd0);
    check("t6_noop_addr", 32'(frame_addr), 32'h0);
    check("t6_pending", 32'(exp_q.size()), 32'd0);
    check("t6_err", 32'(err_seen), 32'(err_exp));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
